// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer.
// Holds the channel count, the HUNT/LOCK state encoding and the default sample width.
// Imported by tdm_demux4 and its write-strobe decoder.
package tdm_pkg;

  localparam int NUM_CH        = 4;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/dec2to4.sv
// One-hot write-strobe decoder: turns a 2-bit channel select plus enable into 4 strobes.
// Purely combinational, zero latency; no flow control.
// Ports: sel_i (channel index), en_i (write enable), strb_o (one-hot strobe, all zero when en_i=0).
module dec2to4
  import tdm_pkg::*;
(
  input  logic [1:0]        sel_i,
  input  logic              en_i,
  output logic [NUM_CH-1:0] strb_o
);

  always_comb begin
    strb_o = '0;
    if (en_i) strb_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Splits a time-multiplexed sample stream into 4 registered channels, framed by frame_sync.
// Latency: one clock from sample acceptance to chN/ch_valid (frame-latched build: outputs
// load one clock after the channel-3 sample). No backpressure: every din_valid sample is taken.
// Ports: clk, rst (async, active-high), din/din_valid/frame_sync in; ch0..ch3, ch_valid,
// frame_done, sync_err, locked out.
// Build option: define TDM_DEMUX_FRAME_LATCH_EN to load all four channels together per frame.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic              err_d;
  logic [NUM_CH-1:0] strb;

  logic [NUM_CH-1:0][WIDTH-1:0] ch_q;
  logic [NUM_CH-1:0]            ch_valid_q;
  logic                         frame_done_q;
  logic                         sync_err_q;

  // Framing FSM: decides which channel (if any) the current sample is written to.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_en   = 1'b0;
    wr_sel  = 2'd0;
    err_d   = 1'b0;
    case (state_q)
      HUNT: begin
        if (din_valid && frame_sync) begin
          state_d = LOCK;
          wr_en   = 1'b1;
          sel_d   = 2'd1;
        end
      end
      LOCK: begin
        if (din_valid) begin
          wr_en = 1'b1;
          if (frame_sync) begin
            // Sync always restarts the frame at ch0; it is only an error mid-frame.
            sel_d = 2'd1;
            err_d = (sel_q != 2'd0);
          end else begin
            wr_sel = sel_q;
            sel_d  = sel_q + 2'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      sel_q      <= 2'd0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      sync_err_q <= err_d;
    end
  end

  dec2to4 u_dec (
    .sel_i  (wr_sel),
    .en_i   (wr_en),
    .strb_o (strb)
  );

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  // Samples collect in shadow registers; the outputs only see a frame once ch3 is in,
  // so a frame aborted by resync never becomes visible.
  logic [NUM_CH-1:0][WIDTH-1:0] shadow_q;
  logic                         pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      pend_q       <= 1'b0;
      ch_q         <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (strb[n]) shadow_q[n] <= din;
      end
      pend_q       <= strb[NUM_CH-1];
      ch_valid_q   <= pend_q ? {NUM_CH{1'b1}} : '0;
      frame_done_q <= pend_q;
      if (pend_q) ch_q <= shadow_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q         <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (strb[n]) ch_q[n] <= din;
      end
      ch_valid_q   <= strb;
      // Resync restarts at ch0, so an aborted frame never produces a ch3 strobe.
      frame_done_q <= strb[NUM_CH-1];
    end
  end
`endif

  assign ch0        = ch_q[0];
  assign ch1        = ch_q[1];
  assign ch2        = ch_q[2];
  assign ch3        = ch_q[3];
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 with hand-computed expectations.
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_valid;
  logic       frame_done;
  logic       sync_err;
  logic       locked;

  int tests_run    = 0;
  int tests_failed = 0;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ch_of(input int i);
    case (i)
      0: return ch0;
      1: return ch1;
      2: return ch2;
      default: return ch3;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ch0"}, 32'(ch0), 32'h0);
    check({tag, ".ch1"}, 32'(ch1), 32'h0);
    check({tag, ".ch2"}, 32'(ch2), 32'h0);
    check({tag, ".ch3"}, 32'(ch3), 32'h0);
    check({tag, ".ch_valid"}, 32'(ch_valid), 32'h0);
    check({tag, ".frame_done"}, 32'(frame_done), 32'h0);
    check({tag, ".sync_err"}, 32'(sync_err), 32'h0);
    check({tag, ".locked"}, 32'(locked), 32'h0);
  endtask

  // Present one sample for one clock; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] v, input logic sync);
    din        = v;
    din_valid  = 1'b1;
    frame_sync = sync;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    din        = 8'h0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef TDM_DEMUX_FRAME_LATCH_EN
    // Basic frame on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      send(8'hA1 + 8'(i), i == 0);
      check($sformatf("frame.ch%0d", i), 32'(ch_of(i)), 32'hA1 + i);
      check($sformatf("frame.vld%0d", i), 32'(ch_valid), 32'(1 << i));
      check($sformatf("frame.done%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("frame.locked%0d", i), 32'(locked), 32'h1);
    end
    idle();
    check("frame.vld_after", 32'(ch_valid), 32'h0);
    check("frame.done_after", 32'(frame_done), 32'h0);

    // No sync yet: samples discarded until frame_sync.
    do_reset();
    send(8'h11, 1'b0);
    check_all_zero("hunt11");
    send(8'h22, 1'b0);
    check_all_zero("hunt22");
    // frame_sync without din_valid is ignored.
    frame_sync = 1'b1;
    idle();
    frame_sync = 1'b0;
    check("sync_novalid.locked", 32'(locked), 32'h0);
    send(8'h33, 1'b1);
    check("hunt.ch0", 32'(ch0), 32'h33);
    check("hunt.vld", 32'(ch_valid), 32'h1);
    check("hunt.locked", 32'(locked), 32'h1);

    // Misplaced sync at sel=2.
    send(8'h44, 1'b0);
    check("resync.ch1_pre", 32'(ch1), 32'h44);
    send(8'h55, 1'b1);
    check("resync.err", 32'(sync_err), 32'h1);
    check("resync.ch0", 32'(ch0), 32'h55);
    check("resync.vld", 32'(ch_valid), 32'h1);
    check("resync.done", 32'(frame_done), 32'h0);
    check("resync.locked", 32'(locked), 32'h1);
    send(8'h66, 1'b0);
    check("resync.ch1", 32'(ch1), 32'h66);
    check("resync.vld1", 32'(ch_valid), 32'h2);
    check("resync.err_clr", 32'(sync_err), 32'h0);
    check("resync.ch2_held", 32'(ch2), 32'h0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    check("resync.ch3", 32'(ch3), 32'h88);
    check("resync.done3", 32'(frame_done), 32'h1);
    // Sync on a frame boundary is not an error.
    send(8'h99, 1'b1);
    check("bound.err", 32'(sync_err), 32'h0);
    check("bound.ch0", 32'(ch0), 32'h99);
    check("bound.ch3_held", 32'(ch3), 32'h88);

    // Frame with 3-cycle gaps between samples.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), i == 0);
      check($sformatf("gap.ch%0d", i), 32'(ch_of(i)), 32'(i + 1));
      check($sformatf("gap.vld%0d", i), 32'(ch_valid), 32'(1 << i));
      check($sformatf("gap.done%0d", i), 32'(frame_done), (i == 3) ? 32'h1 : 32'h0);
      for (int g = 0; g < 3; g++) begin
        idle();
        check($sformatf("gap.idle_vld%0d_%0d", i, g), 32'(ch_valid), 32'h0);
        check($sformatf("gap.idle_done%0d_%0d", i, g), 32'(frame_done), 32'h0);
        check($sformatf("gap.idle_ch%0d_%0d", i, g), 32'(ch_of(i)), 32'(i + 1));
      end
    end

    // Asynchronous reset mid-frame.
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    check("mid.ch1", 32'(ch1), 32'h20);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h30, 1'b0);
    check_all_zero("post_rst");
`else
    // Frame-latched outputs: nothing visible until the edge after the ch3 sample.
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), i == 0);
      check($sformatf("latch.vld%0d", i), 32'(ch_valid), 32'h0);
      check($sformatf("latch.ch%0d_held", i), 32'(ch_of(i)), 32'h0);
      check($sformatf("latch.done%0d", i), 32'(frame_done), 32'h0);
    end
    idle();
    for (int i = 0; i < 4; i++)
      check($sformatf("latch.ch%0d", i), 32'(ch_of(i)), 32'hA0 + i);
    check("latch.vld", 32'(ch_valid), 32'hF);
    check("latch.done", 32'(frame_done), 32'h1);
    idle();
    check("latch.vld_after", 32'(ch_valid), 32'h0);
    // Aborted frame never reaches outputs.
    send(8'hB0, 1'b1);
    send(8'hB1, 1'b0);
    send(8'hC0, 1'b1);
    check("latch.err", 32'(sync_err), 32'h1);
    idle();
    check("latch.abort_ch0", 32'(ch0), 32'hA0);
    check("latch.abort_vld", 32'(ch_valid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
